// File: rtl/mod_unit_arbiter_if.sv
// Bus bundle between the modulo-unit arbiter, its requesters and the unit.
// master: arbiter side; slave: requesters plus the modulo unit.
interface mod_unit_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 16
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_count;
    logic [NREQ*W-1:0] req_which;
    logic [NREQ-1:0]   gnt_done;
    logic [W-1:0]      gnt_address;
    logic              gnt_err;
    logic              busy;
    logic              start_rng_address;
    logic [W-1:0]      betterNeighborCount;
    logic [W-1:0]      which;
    logic [W-1:0]      rng_address;
    logic              done_rng_address;

    modport master (
        input  req, req_count, req_which,
        input  rng_address, done_rng_address,
        output gnt_done, gnt_address, gnt_err, busy,
        output start_rng_address, betterNeighborCount, which
    );

    modport slave (
        output req, req_count, req_which,
        output rng_address, done_rng_address,
        input  gnt_done, gnt_address, gnt_err, busy,
        input  start_rng_address, betterNeighborCount, which
    );
endinterface

// File: rtl/mod_unit_arbiter.sv
// Round-robin arbiter sharing one modulo-reduction unit among NREQ requesters.
// Ports: clock, rst (sync, active-high), bus (mod_unit_arbiter_if.master).
module mod_unit_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 16
) (
    input  logic                clock,
    input  logic                rst,
    mod_unit_arbiter_if.master  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]    state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;
    logic [W-1:0]  count_q;
    logic [W-1:0]  which_q;
    logic [W-1:0]  result_q;
    logic          err_q;

    logic          found;
    logic [IW-1:0] win;
    logic [IW-1:0] ptr_nxt;
    logic [W-1:0]  win_count;
    logic [W-1:0]  win_which;
    int            j;

    // First set request at or above ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!found && bus.req[j]) begin
                found = 1'b1;
                win   = IW'(j);
            end
        end
    end

    assign win_count = bus.req_count[win*W +: W];
    assign win_which = bus.req_which[win*W +: W];
    assign ptr_nxt   = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge clock) begin
        if (rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            idx      <= '0;
            count_q  <= '0;
            which_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (found) begin
                        idx     <= win;
                        ptr     <= ptr_nxt;
                        count_q <= win_count;
                        which_q <= win_which;
                        // A zero divisor would hang the unit: answer directly.
                        if (win_count == '0) begin
                            result_q <= '0;
                            err_q    <= 1'b1;
                            state    <= S_RESP;
                        end else begin
                            err_q <= 1'b0;
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: state <= S_WAIT;
                // done is cleared by the unit on the start edge, so any
                // done seen here belongs to this transaction.
                S_WAIT: begin
                    if (bus.done_rng_address) begin
                        result_q <= bus.rng_address;
                        state    <= S_RESP;
                    end
                end
                S_RESP: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [NREQ-1:0] onehot;

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

    assign bus.busy                = (state != S_IDLE);
    assign bus.start_rng_address   = (state == S_ISSUE);
    assign bus.betterNeighborCount = count_q;
    assign bus.which               = which_q;
    assign bus.gnt_done    = (state == S_RESP) ? onehot : '0;
    assign bus.gnt_address = (state == S_RESP) ? result_q : '0;
    assign bus.gnt_err     = (state == S_RESP) & err_q;
endmodule

// File: tb/tb_mod_unit_arbiter.sv
// Testbench for mod_unit_arbiter with a subtract-loop modulo unit model.
// Expected grants are queued when requests are driven and popped on gnt_done.
module tb_mod_unit_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 16;

    typedef struct {
        int           idx;
        logic [W-1:0] addr;
        logic         err;
    } exp_t;

    logic clock = 1'b0;
    logic rst   = 1'b1;

    always #5 clock = ~clock;

    mod_unit_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    mod_unit_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    // Modulo unit: repeated subtraction, done sticky until next start.
    logic         u_busy;
    logic         u_done;
    logic [W-1:0] u_rem;
    logic [W-1:0] u_div;
    logic [W-1:0] u_res;

    always @(posedge clock) begin
        if (rst) begin
            u_busy <= 1'b0;
            u_done <= 1'b0;
            u_rem  <= '0;
            u_div  <= '0;
            u_res  <= '0;
        end else if (bus.start_rng_address) begin
            u_busy <= 1'b1;
            u_done <= 1'b0;
            u_rem  <= bus.which;
            u_div  <= bus.betterNeighborCount;
        end else if (u_busy) begin
            if (u_rem >= u_div) begin
                u_rem <= u_rem - u_div;
            end else begin
                u_busy <= 1'b0;
                u_done <= 1'b1;
                u_res  <= u_rem;
            end
        end
    end

    assign bus.rng_address      = u_res;
    assign bus.done_rng_address = u_done;

    // Start-pulse monitor.
    int cyc        = 0;
    int start_cnt  = 0;
    int zero_start = 0;
    int last_start = -1;
    int min_gap    = 1000000;

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (bus.start_rng_address) begin
            start_cnt = start_cnt + 1;
            if (bus.betterNeighborCount == '0)
                zero_start = zero_start + 1;
            if (last_start >= 0 && (cyc - last_start) < min_gap)
                min_gap = cyc - last_start;
            last_start = cyc;
        end
    end

    task automatic do_reset();
        bus.req = '0;
        rst = 1'b1;
        repeat (2) @(negedge clock);
        rst = 1'b0;
        q.delete();
        last_start = -1;
        min_gap = 1000000;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] wh,
                          input logic [W-1:0] cnt);
        exp_t e;
        bus.req_which[i*W +: W] = wh;
        bus.req_count[i*W +: W] = cnt;
        bus.req[i] = 1'b1;
        e.idx  = i;
        e.addr = (cnt == 0) ? '0 : wh % cnt;
        e.err  = (cnt == 0);
        q.push_back(e);
    endtask

    // Waits (bounded) for a grant; samples at negedge.
    task automatic wait_grant(output logic [NREQ-1:0] g,
                              output logic [W-1:0] a,
                              output logic er, output int n);
        bit ok;
        ok = 0;
        n  = 0;
        g  = '0;
        a  = '0;
        er = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            n++;
            if (bus.gnt_done != '0) begin
                g  = bus.gnt_done;
                a  = bus.gnt_address;
                er = bus.gnt_err;
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: no gnt_done within 300 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy: got %b want 0", bus.busy);
        end
        checks++;
        if (bus.gnt_done !== '0) begin
            errors++;
            $display("FAIL rst_gnt_done: got %b want 0", bus.gnt_done);
        end
        checks++;
        if (bus.start_rng_address !== 1'b0) begin
            errors++;
            $display("FAIL rst_start: got %b want 0", bus.start_rng_address);
        end
        checks++;
        if (bus.gnt_address !== '0 || bus.gnt_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_gnt: got addr %0d err %b want 0 0",
                     bus.gnt_address, bus.gnt_err);
        end
        checks++;
        if (bus.betterNeighborCount !== '0 || bus.which !== '0) begin
            errors++;
            $display("FAIL rst_operands: got %0d %0d want 0 0",
                     bus.betterNeighborCount, bus.which);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [NREQ-1:0] g;
        logic [W-1:0]    a;
        logic            er;
        int              n;
        int              sc;
        exp_t            e;
        do_reset();
        sc = start_cnt;
        set_op(0, 16'd10, 16'd3);
        @(negedge clock);
        bus.req = '0;
        checks++;
        if (bus.start_rng_address !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_issue: start %b busy %b want 1 1",
                     bus.start_rng_address, bus.busy);
        end
        checks++;
        if (bus.betterNeighborCount !== 16'd3 || bus.which !== 16'd10) begin
            errors++;
            $display("FAIL single_operands: got %0d %0d want 3 10",
                     bus.betterNeighborCount, bus.which);
        end
        wait_grant(g, a, er, n);
        e = q.pop_front();
        checks++;
        if (g !== 4'b0001 || a !== e.addr || er !== e.err) begin
            errors++;
            $display("FAIL single_grant: got %b/%0d/%b want 0001/%0d/%b",
                     g, a, er, e.addr, e.err);
        end
        checks++;
        if (start_cnt - sc !== 1) begin
            errors++;
            $display("FAIL single_starts: got %0d want 1", start_cnt - sc);
        end
    endtask

    task automatic test_small_dividend();
        logic [NREQ-1:0] g;
        logic [W-1:0]    a;
        logic            er;
        int              n;
        exp_t            e;
        do_reset();
        set_op(1, 16'd2, 16'd7);
        wait_grant(g, a, er, n);
        bus.req = '0;
        e = q.pop_front();
        checks++;
        if (g !== 4'b0010 || a !== e.addr || er !== 1'b0) begin
            errors++;
            $display("FAIL small_dividend: got %b/%0d/%b want 0010/%0d/0",
                     g, a, er, e.addr);
        end
    endtask

    task automatic test_zero_div();
        logic [NREQ-1:0] g;
        logic [W-1:0]    a;
        logic            er;
        int              n;
        int              sc;
        exp_t            e;
        do_reset();
        sc = start_cnt;
        set_op(2, 16'd5, 16'd0);
        wait_grant(g, a, er, n);
        bus.req = '0;
        e = q.pop_front();
        checks++;
        if (g !== 4'b0100 || a !== e.addr || er !== 1'b1) begin
            errors++;
            $display("FAIL zero_div_grant: got %b/%0d/%b want 0100/0/1",
                     g, a, er);
        end
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL zero_div_latency: got %0d want 1", n);
        end
        checks++;
        if (start_cnt !== sc || zero_start !== 0) begin
            errors++;
            $display("FAIL zero_div_start: starts %0d zero-starts %0d want 0 0",
                     start_cnt - sc, zero_start);
        end
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] g;
        logic [W-1:0]    a;
        logic            er;
        int              n;
        exp_t            e;
        do_reset();
        for (int i = 0; i < NREQ; i++)
            set_op(i, 16'(i * 5 + 7), 16'(i + 2));
        for (int k = 0; k < 5; k++) begin
            wait_grant(g, a, er, n);
            bus.req = bus.req & ~g;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL fair_queue: empty at grant %0d", k);
            end else begin
                e = q.pop_front();
                if (g !== NREQ'(1 << e.idx) || a !== e.addr || er !== e.err) begin
                    errors++;
                    $display("FAIL fair_grant%0d: got %b/%0d want idx %0d/%0d",
                             k, g, a, e.idx, e.addr);
                end
            end
            if (k == 0) begin
                @(negedge clock);
                set_op(0, 16'd100, 16'd9);
            end
        end
        checks++;
        if (q.size() !== 0) begin
            errors++;
            $display("FAIL fair_leftover: got %0d want 0", q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [NREQ-1:0] g;
        logic [W-1:0]    a;
        logic            er;
        int              n;
        exp_t            e;
        do_reset();
        set_op(0, 16'd10, 16'd3);
        set_op(1, 16'd20, 16'd7);
        for (int k = 0; k < 2; k++) begin
            wait_grant(g, a, er, n);
            bus.req = bus.req & ~g;
            e = q.pop_front();
            checks++;
            if (g !== NREQ'(1 << e.idx) || a !== e.addr || er !== e.err) begin
                errors++;
                $display("FAIL b2b_grant%0d: got %b/%0d want idx %0d/%0d",
                         k, g, a, e.idx, e.addr);
            end
        end
        checks++;
        if (min_gap < 2) begin
            errors++;
            $display("FAIL b2b_start_gap: got %0d want >=2", min_gap);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [NREQ-1:0] g;
        logic [W-1:0]    a;
        logic            er;
        int              n;
        exp_t            e;
        do_reset();
        set_op(0, 16'hFFFF, 16'd1);
        repeat (20) @(negedge clock);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL midwait_busy: got %b want 1", bus.busy);
        end
        rst = 1'b1;
        bus.req = '0;
        q.delete();
        @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0 || bus.gnt_done !== '0 ||
            bus.start_rng_address !== 1'b0 || bus.gnt_err !== 1'b0 ||
            bus.gnt_address !== '0) begin
            errors++;
            $display("FAIL midwait_rst_ctl: busy %b done %b start %b err %b addr %0d want 0",
                     bus.busy, bus.gnt_done, bus.start_rng_address,
                     bus.gnt_err, bus.gnt_address);
        end
        checks++;
        if (bus.betterNeighborCount !== '0 || bus.which !== '0) begin
            errors++;
            $display("FAIL midwait_rst_ops: got %0d %0d want 0 0",
                     bus.betterNeighborCount, bus.which);
        end
        rst = 1'b0;
        last_start = -1;
        set_op(0, 16'd9, 16'd4);
        wait_grant(g, a, er, n);
        bus.req = '0;
        e = q.pop_front();
        checks++;
        if (g !== 4'b0001 || a !== e.addr || er !== 1'b0) begin
            errors++;
            $display("FAIL midwait_after: got %b/%0d/%b want 0001/%0d/0",
                     g, a, er, e.addr);
        end
    endtask

    initial begin
        bus.req       = '0;
        bus.req_count = '0;
        bus.req_which = '0;
        test_reset();
        test_single();
        test_small_dividend();
        test_zero_div();
        test_fairness();
        test_back_to_back();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
